// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encoding and baud helper for the UART receiver
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - ready/valid read port of the receive FIFO
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_out_valid;
  logic                 data_out_ready;

  modport master (output data_out, output data_out_valid, input data_out_ready);
  modport slave  (input data_out, input data_out_valid, output data_out_ready);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, power-of-two depth, push accepted when full if a pop happens
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Head is masked while empty so the read port shows zero after reset.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - parametrised UART receiver (data/parity/stop configurable) feeding a receive FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         serial_in,
  uart_rx_fifo_if.master               out_if,
  output logic                         frame_err,
  output logic                         parity_err,
  output logic                         overrun,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
  localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME);
  localparam int BW               = 4;

  logic                 sync1_q, rx_q, rx_prev_q;
  uart_state_e          state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d, frm_err_q, frm_err_d, done_q, done_d;
  logic                 at_sample, at_edge, exp_parity;
  logic                 push, pop, full, empty;

  assign at_sample  = (clk_cnt_q == CW'(SAMPLE_TIME - 1));
  assign at_edge    = (clk_cnt_q == CW'(SYMBOL_EDGE_TIME - 1));
  assign exp_parity = (PARITY == PARITY_EVEN) ? ^shift_q : ~^shift_q;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (rx_prev_q && !rx_q) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
        end
      end
      ST_START: if (at_sample) begin
        clk_cnt_d = '0;
        state_d   = rx_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (at_edge) begin
        clk_cnt_d = '0;
        shift_d   = {rx_q, shift_q[DATA_BITS-1:1]};
        if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
          bit_cnt_d = '0;
          state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      ST_PARITY: if (at_edge) begin
        clk_cnt_d = '0;
        par_err_d = (rx_q != exp_parity);
        state_d   = ST_STOP;
      end
      ST_STOP: if (at_edge) begin
        clk_cnt_d = '0;
        if (!rx_q) frm_err_d = 1'b1;
        // Back to IDLE right at the last stop sample so a back-to-back start edge is not missed.
        if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
          bit_cnt_d = '0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rx_q      <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sync1_q   <= serial_in;
      rx_q      <= sync1_q;
      rx_prev_q <= rx_q;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      done_q    <= done_d;
    end
  end

  assign push       = done_q && !par_err_q && !frm_err_q;
  assign pop        = out_if.data_out_valid && out_if.data_out_ready;
  assign frame_err  = done_q && frm_err_q;
  assign parity_err = done_q && par_err_q;
  assign overrun    = push && full && !pop;
  assign out_if.data_out_valid = !empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (out_if.data_out_ready),
    .head_o      (out_if.data_out),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (fifo_count)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed and random frames on an 8N1 and a 7E2 receiver against a frame-level model
module tb_uart_rx_fifo;
  localparam int SYM_A = 1_000_000 / 62_500;
  localparam int SYM_B = 1_000_000 / 52_631;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;
  logic ser_a = 1'b1, ser_b = 1'b1;
  logic fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;
  logic [2:0] cnt_a, cnt_b;

  int vectors = 0;
  int miscompares = 0;
  int fe_cnt [2], pe_cnt [2], ov_cnt [2];
  int exp_fe [2], exp_pe [2], exp_ov [2];
  int occ [2];
  int got_rd [2];
  logic [8:0] got_a [$], got_b [$], exp_a [$], exp_b [$];

  uart_rx_fifo_if #(.DATA_BITS(8)) if_a ();
  uart_rx_fifo_if #(.DATA_BITS(7)) if_b ();

  uart_rx_fifo #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(62_500), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst_a), .serial_in(ser_a), .out_if(if_a.master),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .fifo_count(cnt_a));

  uart_rx_fifo #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(52_631), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst_b), .serial_in(ser_b), .out_if(if_b.master),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b), .fifo_count(cnt_b));

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 2; i++) begin
      fe_cnt[i] = 0; pe_cnt[i] = 0; ov_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_a) begin
      if (if_a.data_out_valid && if_a.data_out_ready) got_a.push_back({1'b0, if_a.data_out});
      fe_cnt[0] += int'(fe_a); pe_cnt[0] += int'(pe_a); ov_cnt[0] += int'(ov_a);
    end
    if (!rst_b) begin
      if (if_b.data_out_valid && if_b.data_out_ready) got_b.push_back({2'b0, if_b.data_out});
      fe_cnt[1] += int'(fe_b); pe_cnt[1] += int'(pe_b); ov_cnt[1] += int'(ov_b);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic par_rule(input logic [8:0] d, input int nb, input int par);
    int ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    return (par == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction

  task automatic model_frame(input bit sel, input logic [8:0] data, input int nb, input int par,
                             input logic pbit, input bit stops_ok);
    logic [8:0] w;
    bit perr, ferr, rdy;
    w = data & 9'((1 << nb) - 1);
    perr = (par != 0) && (pbit != par_rule(data, nb, par));
    ferr = !stops_ok;
    rdy = sel ? if_b.data_out_ready : if_a.data_out_ready;
    if (perr) exp_pe[sel]++;
    if (ferr) exp_fe[sel]++;
    if (!perr && !ferr) begin
      if (!rdy && occ[sel] == DEPTH) exp_ov[sel]++;
      else begin
        if (sel) exp_b.push_back(w); else exp_a.push_back(w);
        if (!rdy) occ[sel]++;
      end
    end
  endtask

  task automatic drive(input bit sel, input bit v, input int n);
    if (sel) ser_b = v; else ser_a = v;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bit sel, input logic [8:0] data, input bit flip_par, input int bad_stop);
    int sym, nb, par, ns;
    logic pbit;
    bit stops_ok;
    sym = sel ? SYM_B : SYM_A;
    nb  = sel ? 7 : 8;
    par = sel ? 2 : 0;
    ns  = sel ? 2 : 1;
    drive(sel, 1'b0, sym);
    for (int i = 0; i < nb; i++) drive(sel, data[i], sym);
    pbit = par_rule(data, nb, par) ^ flip_par;
    if (par != 0) drive(sel, pbit, sym);
    stops_ok = 1'b1;
    for (int i = 0; i < ns; i++) begin
      drive(sel, (i != bad_stop), sym);
      if (i == bad_stop) stops_ok = 1'b0;
    end
    drive(sel, 1'b1, stops_ok ? 0 : sym);
    model_frame(sel, data, nb, par, pbit, stops_ok);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp_stream(input bit sel, input string tag);
    int n_got, n_exp;
    n_got = (sel ? got_b.size() : got_a.size()) - got_rd[sel];
    n_exp = sel ? exp_b.size() : exp_a.size();
    check({tag, "_words"}, 32'(n_got), 32'(n_exp));
    for (int i = 0; i < n_exp && i < n_got; i++)
      check({tag, "_data"}, 32'(sel ? got_b[got_rd[1] + i] : got_a[got_rd[0] + i]),
            32'(sel ? exp_b[i] : exp_a[i]));
    check({tag, "_frame_err"}, 32'(fe_cnt[sel]), 32'(exp_fe[sel]));
    check({tag, "_parity_err"}, 32'(pe_cnt[sel]), 32'(exp_pe[sel]));
    check({tag, "_overrun"}, 32'(ov_cnt[sel]), 32'(exp_ov[sel]));
    got_rd[sel] = sel ? got_b.size() : got_a.size();
    if (sel) exp_b.delete(); else exp_a.delete();
    occ[sel] = 0;
  endtask

  initial begin
    int lat;
    int nframes;
    logic [8:0] w;
    int bad;
    for (int i = 0; i < 2; i++) begin
      exp_fe[i] = 0; exp_pe[i] = 0; exp_ov[i] = 0; occ[i] = 0; got_rd[i] = 0;
    end
    if_a.data_out_ready = 1'b1;
    if_b.data_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(if_a.data_out_valid), 32'(0));
    check("rst_count", 32'(cnt_a), 32'(0));
    check("rst_data", 32'(if_a.data_out), 32'(0));
    check("rst_flags", 32'({fe_a, pe_a, ov_a}), 32'(0));
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    settle(4);

    // Back-to-back 8N1 frames with the consumer always ready.
    send(0, 9'hAC, 0, -1);
    send(0, 9'hAF, 0, -1);
    settle(6);
    cmp_stream(0, "b2b");

    // Latency from the start-bit falling edge to valid with an empty FIFO.
    if_a.data_out_ready = 1'b0;
    lat = -1;
    fork
      send(0, 9'h5A, 0, -1);
      begin
        for (int k = 1; k <= 400; k++) begin
          @(negedge clk);
          if (if_a.data_out_valid) begin
            lat = k - 1;
            break;
          end
        end
      end
    join
    check("latency_in_window", 32'((lat >= 2 + SYM_A / 2 + 9 * SYM_A) && (lat <= 4 + SYM_A / 2 + 9 * SYM_A)), 32'(1));
    check("latency_head", 32'(if_a.data_out), 32'(8'h5A));
    if_a.data_out_ready = 1'b1;
    settle(4);
    cmp_stream(0, "latency");

    // Fill the FIFO with the consumer stalled; the fifth good frame overruns.
    if_a.data_out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(0, 9'(i), 0, -1);
    settle(6);
    check("full_count", 32'(cnt_a), 32'(occ[0]));
    check("full_head", 32'(if_a.data_out), 32'(exp_a[0]));
    if_a.data_out_ready = 1'b1;
    settle(8);
    check("drained_count", 32'(cnt_a), 32'(0));
    cmp_stream(0, "overrun");

    // 7E2: good parity queues, flipped parity is reported and leaves occupancy alone.
    if_b.data_out_ready = 1'b0;
    send(1, 9'h55, 0, -1);
    settle(6);
    check("par_ok_count", 32'(cnt_b), 32'(occ[1]));
    send(1, 9'h55, 1, -1);
    settle(6);
    check("par_bad_count", 32'(cnt_b), 32'(occ[1]));
    check("par_bad_pulse", 32'(pe_cnt[1]), 32'(exp_pe[1]));
    if_b.data_out_ready = 1'b1;
    settle(6);
    cmp_stream(1, "parity");

    // Low stop bit, then the same word sent cleanly.
    send(0, 9'h3C, 0, 0);
    send(0, 9'h3C, 0, -1);
    settle(6);
    cmp_stream(0, "framing");

    // Short low glitch is a false start.
    ser_a = 1'b0;
    settle(4);
    ser_a = 1'b1;
    settle(3 * SYM_A);
    check("glitch_count", 32'(cnt_a), 32'(0));
    cmp_stream(0, "glitch");
    send(0, 9'h96, 0, -1);
    settle(6);
    cmp_stream(0, "after_glitch");

    // Reset in the middle of a data bit with two words queued.
    if_a.data_out_ready = 1'b0;
    send(0, 9'h11, 0, -1);
    send(0, 9'h22, 0, -1);
    settle(4);
    check("pre_rst_count", 32'(cnt_a), 32'(occ[0]));
    drive(0, 1'b0, SYM_A);
    drive(0, 1'b1, SYM_A);
    drive(0, 1'b0, SYM_A);
    drive(0, 1'b1, SYM_A / 2);
    rst_a = 1'b1;
    ser_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    exp_a.delete();
    occ[0] = 0;
    @(negedge clk);
    check("mid_rst_count", 32'(cnt_a), 32'(0));
    check("mid_rst_valid", 32'(if_a.data_out_valid), 32'(0));
    check("mid_rst_data", 32'(if_a.data_out), 32'(0));
    check("mid_rst_flags", 32'({fe_a, pe_a, ov_a}), 32'(0));
    settle(12 * SYM_A);
    if_a.data_out_ready = 1'b1;
    send(0, 9'hA5, 0, -1);
    settle(6);
    cmp_stream(0, "post_rst");

    // Random 8N1 stream with occasional framing errors and random gaps.
    nframes = 12;
    for (int i = 0; i < nframes; i++) begin
      w = 9'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0) ? 0 : -1;
      send(0, w, 0, bad);
      settle($urandom_range(0, 2 * SYM_A));
    end
    settle(8);
    cmp_stream(0, "rand_a");

    // Random 7E2 stream with parity flips and either stop bit low.
    nframes = 10;
    for (int i = 0; i < nframes; i++) begin
      w = 9'($urandom_range(0, 127));
      bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1)) : -1;
      send(1, w, ($urandom_range(0, 3) == 0), bad);
      settle($urandom_range(0, 2 * SYM_B));
    end
    settle(8);
    cmp_stream(1, "rand_b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with a built-in receive FIFO, used on the CPU's FPGA_SERIAL_RX path.
- Generalises the fixed 8N1 receiver: configurable data bits, parity and stop bits, plus framing/parity/overrun detection.
- Frames are deserialised by mid-bit sampling at CLOCK_FREQ/BAUD_RATE and queued in a FIFO.
- The CPU drains the FIFO over a ready/valid interface.

Parameters:
- CLOCK_FREQ, 125_000_000: clk frequency in Hz.
- BAUD_RATE, 115_200: serial bit rate.
- DATA_BITS, 8: payload bits per frame. Legal values 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries. Power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- serial_in  in  1  asynchronous serial line. Idle high.
- data_out  out  DATA_BITS  FIFO head word.
- data_out_valid  out  1  FIFO non-empty.
- data_out_ready  in  1  consumer accepts head word.
- frame_err  out  1  one-cycle pulse: a stop bit was sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- overrun  out  1  one-cycle pulse: good frame dropped because the FIFO was full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.

Behaviour:
- Constants: SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (integer division; 1085 at defaults). SAMPLE_TIME = SYMBOL_EDGE_TIME/2 (542).
- Input sync: serial_in passes through a 2-flop synchroniser, reset value 1. All logic uses the synchronised value rx.
- Reset (any time, including mid-frame):
  - FSM goes to IDLE; bit and clock counters cleared.
  - FIFO emptied: data_out_valid=0, fifo_count=0.
  - frame_err, parity_err and overrun all 0.
  - data_out reads 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on rx going 1->0, go to START and clear the clock counter.
- START: at count SAMPLE_TIME-1, sample rx.
  - rx=1: false start, return to IDLE with no flags.
  - rx=0: clear counter, go to DATA.
- DATA: sample rx each time the counter reaches SYMBOL_EDGE_TIME-1, then clear the counter.
  - Bits are shifted in LSB first.
  - After DATA_BITS samples, go to PARITY if PARITY!=0, else STOP.
- PARITY: one sample. Expected bit is XOR(data) for even, ~XOR(data) for odd. The mismatch result is latched.
- STOP: STOP_BITS samples, each checked for 1. Any 0 latches a framing error.
- Frame completion (the cycle after the last stop sample):
  - Any error: pulse the matching flag(s) for exactly 1 cycle; the word is discarded.
  - Otherwise push the word. If the FIFO is full and no pop occurs that cycle, drop the word and pulse overrun.
  - Return to IDLE on the same transition, so the next start edge is recognised half a bit after the stop sample. Back-to-back frames must not be lost.
- FIFO read side:
  - data_out is combinational from the head entry.
  - data_out_valid = (fifo_count != 0).
  - Pop when data_out_valid && data_out_ready. Ready while empty is ignored.
- FIFO full with simultaneous push and pop: both are accepted, count unchanged, no overrun.
- FIFO empty with push: data_out_valid rises the next cycle. Fall-through is not required.
- Pointers: $clog2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH. fifo_count saturates at neither end; the flags above prevent underflow and overflow.
- Latency: from the serial_in falling edge to data_out_valid (FIFO empty) = 2 + SAMPLE_TIME + (DATA_BITS + (PARITY!=0) + STOP_BITS)*SYMBOL_EDGE_TIME + 1 cycles, ±1 for edge alignment.

Decomposition:
- uart_pkg holds:
  - PARITY_NONE/ODD/EVEN constants.
  - The FSM state encoding.
  - A function computing SYMBOL_EDGE_TIME from the two frequency parameters.
- One sub-module: sync_fifo (WIDTH, DEPTH; push/pop, full/empty/count). Reusable for a future TX FIFO.
- The synchroniser is inline; it is not a separate module.

Test Plan:
1. Defaults (8N1, 1085 cycles/bit): send 0xAC then 0xAF back-to-back, data_out_ready=1 -> two words 0xAC, 0xAF in order. No error pulses.
2. Hold data_out_ready=0 and send 5 frames (0x01..0x05) with FIFO_DEPTH=4 -> fifo_count reaches 4, one overrun pulse on frame 5. Draining yields 0x01..0x04.
3. PARITY=2 (even), DATA_BITS=7: send 0x55 with correct parity -> accepted. Resend with flipped parity bit -> one parity_err pulse, fifo_count unchanged.
4. Stop bit driven low for 0x3C -> one frame_err pulse, no push. The next correct frame 0x3C is received normally.
5. Glitch: serial_in low for 300 cycles, then high -> no flags, no push, FSM back in IDLE.
6. Assert rst for 1 cycle mid-data-bit of a frame with 2 words queued -> fifo_count=0, data_out_valid=0, flags 0. A subsequent clean frame 0xA5 is received correctly.
